// File: rtl/nes_pad_reader_if.sv
// ----------------------------------------------------------------------------
// nes_pad_reader_if : pad-side serial lines plus host-side scan results
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface nes_pad_reader_if;
  logic       poll_en;
  logic       ctrl_data;
  logic       ctrl_latch;
  logic       ctrl_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  modport master (
    input  poll_en, ctrl_data,
    output ctrl_latch, ctrl_clk, buttons, valid, busy
  );

  modport slave (
    output poll_en, ctrl_data,
    input  ctrl_latch, ctrl_clk, buttons, valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/nes_pad_reader.sv
// ----------------------------------------------------------------------------
// nes_pad_reader : free-running NES pad scanner, latched active-high buttons
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nes_pad_reader #(
  parameter int CLK_DIV     = 150,
  parameter int POLL_PERIOD = 416667
) (
  input  logic             clk,
  input  logic             reset,
  nes_pad_reader_if.master bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] phase_cnt;
  logic [2:0]    bit_idx;
  logic [IW-1:0] idle_cnt;
  logic [7:0]    shift;
  logic          sync1;
  logic          sync2;
  logic          latch_q;
  logic          pclk_q;
  logic [7:0]    buttons_q;
  logic          valid_q;
  logic          busy_q;

  assign bus.ctrl_latch = latch_q;
  assign bus.ctrl_clk   = pclk_q;
  assign bus.buttons    = buttons_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;

  // Resets to 1 so an idle/unplugged line never looks like a pressed button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.ctrl_data;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_idx   <= '0;
      idle_cnt  <= '0;
      shift     <= 8'hFF;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      buttons_q <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (idle_cnt == IDLE_LAST) begin
            if (bus.poll_en) begin
              state     <= LATCH;
              idle_cnt  <= '0;
              phase_cnt <= '0;
              bit_idx   <= '0;
              latch_q   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        // The latch pulse spans two ticks; bit_idx[0] marks the second one.
        LATCH: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            if (bit_idx[0]) begin
              state   <= LOW;
              bit_idx <= '0;
              latch_q <= 1'b0;
              pclk_q  <= 1'b0;
            end else begin
              bit_idx <= 3'd1;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        LOW: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt      <= '0;
            shift[bit_idx] <= sync2;
            state          <= HIGH;
            pclk_q         <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        HIGH: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state     <= DONE;
              buttons_q <= ~shift;
              valid_q   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              state   <= LOW;
              pclk_q  <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          idle_cnt <= '0;
          busy_q   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
// ----------------------------------------------------------------------------
// tb_nes_pad_reader : pad model + scoreboard bench for nes_pad_reader
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nes_pad_reader;

  localparam int T = 4;
  localparam int P = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic poll_en = 1'b1;
  logic glitch = 1'b0;
  logic [7:0] raw_next = 8'hFF;
  logic [7:0] pad_sr = 8'hFF;
  logic prev_valid = 1'b0;
  int cyc;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  nes_pad_reader_if bus ();

  assign bus.poll_en   = poll_en;
  assign bus.ctrl_data = glitch ? 1'b0 : pad_sr[0];

  nes_pad_reader #(.CLK_DIV(T), .POLL_PERIOD(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Pad: parallel-load on latch, bit0 first, advance on each clock rise.
  always @(posedge bus.ctrl_latch) begin
    pad_sr = raw_next;
    sb.push_back(~raw_next);
  end

  always @(posedge bus.ctrl_clk) begin
    if (!bus.ctrl_latch) pad_sr = {1'b1, pad_sr[7:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.valid) begin
        check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got valid with buttons %0h, expected no update", bus.buttons);
        end else begin
          check("buttons", {24'd0, bus.buttons}, {24'd0, sb.pop_front()});
        end
      end
      prev_valid <= bus.valid;
    end
  end

  task automatic check_reset_values(input string name);
    check(name, {20'd0, bus.ctrl_latch, bus.ctrl_clk, bus.buttons, bus.valid, bus.busy},
          {20'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      glitch = ~glitch;
    end
    check_reset_values("reset_values");
    glitch = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_latch(output int at);
    at = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.ctrl_latch) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL latch_timeout: got no latch, expected one within 1000 cycles");
    end
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid, expected one within 1000 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int lat;
    int bad_latch, bad_clk, bad_busy, bad_valid, falls;
    logic pclk_prev;
    logic e_latch, e_low, e_busy, e_valid;
    int seen;

    // Reset and first-scan timing, single button (A).
    poll_en  = 1'b1;
    raw_next = 8'hFE;
    do_reset();
    bad_latch = 0; bad_clk = 0; bad_busy = 0; bad_valid = 0; falls = 0;
    pclk_prev = 1'b1;
    for (int c = 1; c <= 95; c++) begin
      @(negedge clk);
      e_latch = (c >= P) && (c < P + 2*T);
      e_low   = (c >= P + 2*T) && (c < P + 18*T) && (((c - P - 2*T) % (2*T)) < T);
      e_busy  = (c >= P) && (c <= P + 18*T);
      e_valid = (c == P + 18*T);
      if (bus.ctrl_latch !== e_latch) bad_latch++;
      if (bus.ctrl_clk !== !e_low)    bad_clk++;
      if (bus.busy !== e_busy)        bad_busy++;
      if (bus.valid !== e_valid)      bad_valid++;
      if (pclk_prev && !bus.ctrl_clk) falls++;
      pclk_prev = bus.ctrl_clk;
    end
    check("latch_window_errs", bad_latch, 0);
    check("ctrl_clk_window_errs", bad_clk, 0);
    check("busy_window_errs", bad_busy, 0);
    check("valid_cycle_errs", bad_valid, 0);
    check("ctrl_clk_falls", falls, 8);

    // Bit order, then release all, then random patterns.
    raw_next = 8'h5A;
    wait_latch(t);
    check("second_latch_cycle", t, P + (P + 18*T + 1));
    wait_valid(t);
    check("second_valid_cycle", t, P + (P + 18*T + 1) + 18*T);
    raw_next = 8'hFF;
    wait_valid(t);
    for (int k = 0; k < 6; k++) begin
      raw_next = 8'($urandom);
      wait_valid(t);
    end

    // Reset mid-scan with a non-zero button value already held.
    raw_next = 8'h00;
    wait_valid(t);
    raw_next = 8'($urandom);
    wait_latch(lat);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("midscan_reset_values");
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_latch(t);
    check("latch_after_reset", t, P);
    wait_valid(t);

    // Glitch inside a HIGH phase while the pad presents 1.
    raw_next = 8'hFF;
    wait_latch(lat);
    repeat (9*T) @(negedge clk);
    glitch = 1'b1;
    repeat (2) @(negedge clk);
    glitch = 1'b0;
    wait_valid(t);

    // Poll gating.
    poll_en = 1'b0;
    do_reset();
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ctrl_latch || bus.busy) seen++;
    end
    check("gated_no_activity", seen, 0);
    raw_next = 8'($urandom);
    poll_en = 1'b1;
    @(negedge clk);
    check("latch_after_enable", {31'd0, bus.ctrl_latch}, 32'd1);
    repeat (39) @(negedge clk);
    poll_en = 1'b0;
    wait_valid(t);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ctrl_latch) seen++;
    end
    check("no_latch_after_disable", seen, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nes_pad_reader.md
# nes_pad_reader

Serial reader for a standard NES-style game controller. Drives the pad's latch and clock lines, shifts in the 8 button bits, and holds the result as an active-high byte for the decode stage's `controllerIn` input. Sits at the board edge between the pad connector and the CPU pipeline. Scans free-run at a fixed poll rate, so the CPU always sees the most recent complete scan.

## Interface
- `CLK_DIV`, 150, length of one serial phase ("tick", T) in clk cycles; 6 µs at 25 MHz; legal range ≥ 4
- `POLL_PERIOD`, 416667, clk cycles spent idle between scans (~60 Hz at 25 MHz); legal range ≥ 1
- `clk`  input  1  system clock; single clock domain
- `reset`  input  1  asynchronous, active-high
- `poll_en`  input  1  1 = start new scans; 0 = hold in IDLE once any scan in progress finishes
- `ctrl_data`  input  1  serial data from pad; active-low buttons; asynchronous to clk
- `ctrl_latch`  output  1  latch strobe to pad, active-high
- `ctrl_clk`  output  1  serial clock to pad; idles high
- `buttons`  output  8  last complete scan, active-high; bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right
- `valid`  output  1  one-cycle pulse when `buttons` updates
- `busy`  output  1  high from the first LATCH cycle through the DONE cycle

## Operation
- `ctrl_data` passes through a 2-FF synchronizer (reset value 1) before any use.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE.
- Counters:
  - `phase_cnt` counts 0..CLK_DIV-1.
  - `bit_idx` counts 0..7.
  - `idle_cnt` counts 0..POLL_PERIOD-1.
- IDLE:
  - `ctrl_latch`=0, `ctrl_clk`=1, `busy`=0.
  - `idle_cnt` increments each cycle.
  - When `idle_cnt`=POLL_PERIOD-1 and `poll_en`=1: go to LATCH and clear the counter.
  - When `idle_cnt`=POLL_PERIOD-1 and `poll_en`=0: `idle_cnt` saturates there, and the FSM enters LATCH on the first cycle `poll_en`=1.
- LATCH: `ctrl_latch`=1, `ctrl_clk`=1 for 2T cycles. Then LOW with `bit_idx`=0.
- LOW: `ctrl_clk`=0 for T cycles. On the last LOW cycle, write `shift[bit_idx]` from the synchronized data. Then HIGH.
- HIGH: `ctrl_clk`=1 for T cycles. The pad advances its data on this rising edge. On the last HIGH cycle:
  - if `bit_idx`=7, go to DONE;
  - otherwise increment `bit_idx` and go to LOW.
- DONE: one cycle. `buttons` <= ~`shift` is registered, `valid`=1. Then IDLE with `idle_cnt`=0.
- `poll_en` falling mid-scan has no effect until the scan completes. `buttons` updates only in DONE; no partial scans are ever visible.
- A pad that is unplugged reads all 1s (connector pull-up), so `buttons` = 8'h00. No error flag.
- All outputs are registered; no combinational path from `ctrl_data` to any output.

## Timing
- Reset values: `ctrl_latch`=0, `ctrl_clk`=1, `buttons`=8'h00, `valid`=0, `busy`=0, state IDLE, all counters 0, `shift`=8'hFF.
- Reset asserted mid-scan aborts immediately, asynchronously. `buttons` returns to 0. After reset deasserts, the FSM restarts with a full POLL_PERIOD idle.
- Scan length, from the first LATCH cycle to the DONE cycle inclusive: 2T + 16T + 1 cycles.
- Latch-rise to latch-rise period with `poll_en` held high: POLL_PERIOD + 18T + 1.
- Sample point for bit i is T-1 cycles after `ctrl_clk` falls. Synchronizer latency (2 cycles) is covered because T ≥ 4.
- `valid` is high for exactly one cycle per scan, coincident with the first cycle the new `buttons` value is visible.

## Test plan
All scenarios use CLK_DIV=4, POLL_PERIOD=20, and cycles counted from the first clk edge after reset deasserts.
- Reset: hold `reset`, toggle `ctrl_data` -> outputs equal reset values. Release -> `ctrl_latch` high in cycles 20–27. `ctrl_clk` low in cycles 28–31, 36–39, …, 84–87. Exactly 8 falling edges on `ctrl_clk`.
- Single button: pad model drives raw 8'hFE (A pressed, bit0 presented first, advancing on each `ctrl_clk` rise) -> `valid`=1 and `buttons`=8'h01 at cycle 92. Next latch rise at cycle 113.
- Bit order: pressed mask 8'hA5 (raw 8'h5A) -> `buttons`=8'hA5. Then release all -> `buttons`=8'h00 after the following scan.
- Poll gating:
  - `poll_en`=0 from reset -> no latch within 200 cycles, `busy`=0.
  - Raise `poll_en` -> latch rises the next cycle.
  - Drop `poll_en` at cycle 40 of a scan -> that scan completes with `valid`, and no further latch follows.
- Reset mid-scan: assert `reset` at cycle 50 -> same-cycle `ctrl_clk`=1, `ctrl_latch`=0, `buttons`=0, `busy`=0. After release, latch occurs 20 cycles later.
- Glitch immunity: pulse `ctrl_data` low for 2 cycles inside a HIGH phase while the pad presents 1 -> no effect on `buttons`.
